// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds ALU-class ops until both operands are known,
// snooping the ALU and LSB CDBs, and dispatches one ready entry per cycle.
// Ports: clk/rst/rdy/clear control; issue_* request with full back-pressure;
// alu_cdb_* / lsb_cdb_* snoop buses; alu_* registered bundle to the ALU.
module alu_reservation_station #(
  parameter int RS_SIZE   = 16,
  parameter int RS_IDX_W  = 4,
  parameter int ROB_TAG_W = 4,
  parameter int OP_W      = 6,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clear,
  input  logic                 issue_valid,
  input  logic [OP_W-1:0]      issue_op,
  input  logic [DATA_W-1:0]    issue_V1,
  input  logic [DATA_W-1:0]    issue_V2,
  input  logic                 issue_Q1_busy,
  input  logic                 issue_Q2_busy,
  input  logic [ROB_TAG_W-1:0] issue_Q1,
  input  logic [ROB_TAG_W-1:0] issue_Q2,
  input  logic [DATA_W-1:0]    issue_imm,
  input  logic [ADDR_W-1:0]    issue_pc,
  input  logic [ROB_TAG_W-1:0] issue_rob_tag,
  output logic                 full,
  input  logic                 alu_cdb_valid,
  input  logic [ROB_TAG_W-1:0] alu_cdb_tag,
  input  logic [DATA_W-1:0]    alu_cdb_value,
  input  logic                 lsb_cdb_valid,
  input  logic [ROB_TAG_W-1:0] lsb_cdb_tag,
  input  logic [DATA_W-1:0]    lsb_cdb_value,
  output logic [OP_W-1:0]      alu_op_enum,
  output logic [DATA_W-1:0]    alu_V1,
  output logic [DATA_W-1:0]    alu_V2,
  output logic [DATA_W-1:0]    alu_imm,
  output logic [ADDR_W-1:0]    alu_inst_pos,
  output logic [ROB_TAG_W-1:0] alu_rob_tag
);

  // {hit, value}; the ALU bus wins when both carry the tag
  function automatic logic [DATA_W:0] snoop(
    input logic [ROB_TAG_W-1:0] t,
    input logic                 av,
    input logic [ROB_TAG_W-1:0] at,
    input logic [DATA_W-1:0]    ad,
    input logic                 lv,
    input logic [ROB_TAG_W-1:0] lt,
    input logic [DATA_W-1:0]    ld
  );
    logic [DATA_W:0] r;
    r = '0;
    if (lv && lt == t) r = {1'b1, ld};
    if (av && at == t) r = {1'b1, ad};
    return r;
  endfunction

  logic [RS_SIZE-1:0]   busy_q, busy_d;
  logic [RS_SIZE-1:0]   q1_busy_q, q1_busy_d;
  logic [RS_SIZE-1:0]   q2_busy_q, q2_busy_d;
  logic [OP_W-1:0]      op_q  [RS_SIZE];
  logic [OP_W-1:0]      op_d  [RS_SIZE];
  logic [DATA_W-1:0]    v1_q  [RS_SIZE];
  logic [DATA_W-1:0]    v1_d  [RS_SIZE];
  logic [DATA_W-1:0]    v2_q  [RS_SIZE];
  logic [DATA_W-1:0]    v2_d  [RS_SIZE];
  logic [DATA_W-1:0]    imm_q [RS_SIZE];
  logic [DATA_W-1:0]    imm_d [RS_SIZE];
  logic [ADDR_W-1:0]    pc_q  [RS_SIZE];
  logic [ADDR_W-1:0]    pc_d  [RS_SIZE];
  logic [ROB_TAG_W-1:0] q1_q  [RS_SIZE];
  logic [ROB_TAG_W-1:0] q1_d  [RS_SIZE];
  logic [ROB_TAG_W-1:0] q2_q  [RS_SIZE];
  logic [ROB_TAG_W-1:0] q2_d  [RS_SIZE];
  logic [ROB_TAG_W-1:0] tag_q [RS_SIZE];
  logic [ROB_TAG_W-1:0] tag_d [RS_SIZE];

  logic [OP_W-1:0]      alu_op_q, alu_op_d;
  logic [DATA_W-1:0]    alu_v1_q, alu_v1_d;
  logic [DATA_W-1:0]    alu_v2_q, alu_v2_d;
  logic [DATA_W-1:0]    alu_imm_q, alu_imm_d;
  logic [ADDR_W-1:0]    alu_pc_q, alu_pc_d;
  logic [ROB_TAG_W-1:0] alu_tag_q, alu_tag_d;

  logic [DATA_W:0]      wake1 [RS_SIZE];
  logic [DATA_W:0]      wake2 [RS_SIZE];
  logic [DATA_W:0]      byp1, byp2;

  logic                 sel_vld, free_vld;
  logic [RS_IDX_W-1:0]  sel_idx, free_idx;

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_snoop
    assign wake1[g] = snoop(q1_q[g],
      alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
      lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
    assign wake2[g] = snoop(q2_q[g],
      alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
      lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
  end

  // same-cycle bypass for operands arriving with the issue
  assign byp1 = snoop(issue_Q1,
    alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
    lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);
  assign byp2 = snoop(issue_Q2,
    alu_cdb_valid, alu_cdb_tag, alu_cdb_value,
    lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_value);

  assign full = &busy_q;

  // descending scan leaves the lowest matching index
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (busy_q[i] && !q1_busy_q[i] && !q2_busy_q[i]) begin
        sel_vld = 1'b1;
        sel_idx = RS_IDX_W'(i);
      end
      if (!busy_q[i]) begin
        free_vld = 1'b1;
        free_idx = RS_IDX_W'(i);
      end
    end
  end

  always_comb begin
    busy_d    = busy_q;
    q1_busy_d = q1_busy_q;
    q2_busy_d = q2_busy_q;
    op_d      = op_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    q1_d      = q1_q;
    q2_d      = q2_q;
    tag_d     = tag_q;
    alu_op_d  = '0;
    alu_v1_d  = '0;
    alu_v2_d  = '0;
    alu_imm_d = '0;
    alu_pc_d  = '0;
    alu_tag_d = '0;

    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i] && q1_busy_q[i] && wake1[i][DATA_W]) begin
        v1_d[i]      = wake1[i][DATA_W-1:0];
        q1_busy_d[i] = 1'b0;
      end
      if (busy_q[i] && q2_busy_q[i] && wake2[i][DATA_W]) begin
        v2_d[i]      = wake2[i][DATA_W-1:0];
        q2_busy_d[i] = 1'b0;
      end
    end

    if (sel_vld) begin
      alu_op_d        = op_q[sel_idx];
      alu_v1_d        = v1_q[sel_idx];
      alu_v2_d        = v2_q[sel_idx];
      alu_imm_d       = imm_q[sel_idx];
      alu_pc_d        = pc_q[sel_idx];
      alu_tag_d       = tag_q[sel_idx];
      busy_d[sel_idx] = 1'b0;
    end

    // the free slot is never the selected one: select needs busy
    if (issue_valid && free_vld) begin
      busy_d[free_idx]    = 1'b1;
      op_d[free_idx]      = issue_op;
      imm_d[free_idx]     = issue_imm;
      pc_d[free_idx]      = issue_pc;
      tag_d[free_idx]     = issue_rob_tag;
      q1_d[free_idx]      = issue_Q1;
      q2_d[free_idx]      = issue_Q2;
      q1_busy_d[free_idx] = issue_Q1_busy && !byp1[DATA_W];
      q2_busy_d[free_idx] = issue_Q2_busy && !byp2[DATA_W];
      v1_d[free_idx]      = (issue_Q1_busy && byp1[DATA_W]) ?
                            byp1[DATA_W-1:0] : issue_V1;
      v2_d[free_idx]      = (issue_Q2_busy && byp2[DATA_W]) ?
                            byp2[DATA_W-1:0] : issue_V2;
    end

    if (clear) begin
      busy_d    = '0;
      alu_op_d  = '0;
      alu_v1_d  = '0;
      alu_v2_d  = '0;
      alu_imm_d = '0;
      alu_pc_d  = '0;
      alu_tag_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      q1_busy_q <= '0;
      q2_busy_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]  <= '0;
        v1_q[i]  <= '0;
        v2_q[i]  <= '0;
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
        q1_q[i]  <= '0;
        q2_q[i]  <= '0;
        tag_q[i] <= '0;
      end
      alu_op_q  <= '0;
      alu_v1_q  <= '0;
      alu_v2_q  <= '0;
      alu_imm_q <= '0;
      alu_pc_q  <= '0;
      alu_tag_q <= '0;
    end else if (rdy) begin
      busy_q    <= busy_d;
      q1_busy_q <= q1_busy_d;
      q2_busy_q <= q2_busy_d;
      op_q      <= op_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      q1_q      <= q1_d;
      q2_q      <= q2_d;
      tag_q     <= tag_d;
      alu_op_q  <= alu_op_d;
      alu_v1_q  <= alu_v1_d;
      alu_v2_q  <= alu_v2_d;
      alu_imm_q <= alu_imm_d;
      alu_pc_q  <= alu_pc_d;
      alu_tag_q <= alu_tag_d;
    end
  end

  assign alu_op_enum  = alu_op_q;
  assign alu_V1       = alu_v1_q;
  assign alu_V2       = alu_v2_q;
  assign alu_imm      = alu_imm_q;
  assign alu_inst_pos = alu_pc_q;
  assign alu_rob_tag  = alu_tag_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed vector table, hand sequences
// for multi-cycle corners, then random traffic against a reference model.
module tb_alu_reservation_station;

  logic        clk;
  logic        rst, rdy, clear;
  logic        issue_valid;
  logic [5:0]  issue_op;
  logic [31:0] issue_V1, issue_V2, issue_imm, issue_pc;
  logic        issue_Q1_busy, issue_Q2_busy;
  logic [3:0]  issue_Q1, issue_Q2, issue_rob_tag;
  logic        full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_tag, lsb_cdb_tag;
  logic [31:0] alu_cdb_value, lsb_cdb_value;
  logic [5:0]  alu_op_enum;
  logic [31:0] alu_V1, alu_V2, alu_imm, alu_inst_pos;
  logic [3:0]  alu_rob_tag;

  alu_reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_V1(issue_V1), .issue_V2(issue_V2),
    .issue_Q1_busy(issue_Q1_busy), .issue_Q2_busy(issue_Q2_busy),
    .issue_Q1(issue_Q1), .issue_Q2(issue_Q2),
    .issue_imm(issue_imm), .issue_pc(issue_pc),
    .issue_rob_tag(issue_rob_tag), .full(full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag),
    .alu_cdb_value(alu_cdb_value),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag),
    .lsb_cdb_value(lsb_cdb_value),
    .alu_op_enum(alu_op_enum), .alu_V1(alu_V1), .alu_V2(alu_V2),
    .alu_imm(alu_imm), .alu_inst_pos(alu_inst_pos),
    .alu_rob_tag(alu_rob_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic expect_out(input string nm, input int op, input int v1,
                            input int v2, input int rt);
    chk({nm, ".op"}, 32'(alu_op_enum), op);
    chk({nm, ".v1"}, alu_V1, v1);
    chk({nm, ".v2"}, alu_V2, v2);
    chk({nm, ".tag"}, 32'(alu_rob_tag), rt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1; clear = 1'b0; issue_valid = 1'b0;
    issue_op = '0; issue_V1 = '0; issue_V2 = '0;
    issue_Q1_busy = 1'b0; issue_Q2_busy = 1'b0;
    issue_Q1 = '0; issue_Q2 = '0; issue_imm = '0; issue_pc = '0;
    issue_rob_tag = '0;
    alu_cdb_valid = 1'b0; alu_cdb_tag = '0; alu_cdb_value = '0;
    lsb_cdb_valid = 1'b0; lsb_cdb_tag = '0; lsb_cdb_value = '0;
  endtask

  task automatic iss(input int op, input int v1, input int q1b,
                     input int q1, input int v2, input int rt);
    issue_valid = 1'b1;
    issue_op = 6'(op);
    issue_V1 = v1;
    issue_Q1_busy = q1b[0];
    issue_Q1 = 4'(q1);
    issue_V2 = v2;
    issue_Q2_busy = 1'b0;
    issue_Q2 = '0;
    issue_imm = 32'h10 + 32'(op);
    issue_pc = 32'h2000 + 32'(op * 4);
    issue_rob_tag = 4'(rt);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        busy;
    logic [5:0]  op;
    logic [31:0] v1, v2, imm, pc;
    logic        w1, w2;
    logic [3:0]  q1, q2, tag;
  } ent_t;

  ent_t        m [16];
  logic [5:0]  mo_op;
  logic [31:0] mo_v1, mo_v2, mo_imm, mo_pc;
  logic [3:0]  mo_tag;

  function automatic logic bus_hit(input logic [3:0] t,
                                   output logic [31:0] val);
    val = '0;
    if (alu_cdb_valid && alu_cdb_tag == t) begin
      val = alu_cdb_value;
      return 1'b1;
    end
    if (lsb_cdb_valid && lsb_cdb_tag == t) begin
      val = lsb_cdb_value;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic m_full();
    for (int i = 0; i < 16; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = '{default: '0};
    mo_op = '0; mo_v1 = '0; mo_v2 = '0;
    mo_imm = '0; mo_pc = '0; mo_tag = '0;
  endtask

  task automatic model_edge();
    ent_t nx [16];
    int sel, fr;
    logic [31:0] val;
    if (!rdy) return;
    if (clear) begin
      for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
      mo_op = '0; mo_v1 = '0; mo_v2 = '0;
      mo_imm = '0; mo_pc = '0; mo_tag = '0;
      return;
    end
    sel = -1;
    fr = -1;
    for (int i = 0; i < 16; i++) begin
      if (sel < 0 && m[i].busy && !m[i].w1 && !m[i].w2) sel = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    nx = m;
    for (int i = 0; i < 16; i++) begin
      if (nx[i].busy && nx[i].w1 && bus_hit(nx[i].q1, val)) begin
        nx[i].v1 = val; nx[i].w1 = 1'b0;
      end
      if (nx[i].busy && nx[i].w2 && bus_hit(nx[i].q2, val)) begin
        nx[i].v2 = val; nx[i].w2 = 1'b0;
      end
    end
    if (sel >= 0) begin
      mo_op = m[sel].op; mo_v1 = m[sel].v1; mo_v2 = m[sel].v2;
      mo_imm = m[sel].imm; mo_pc = m[sel].pc; mo_tag = m[sel].tag;
      nx[sel].busy = 1'b0;
    end else begin
      mo_op = '0; mo_v1 = '0; mo_v2 = '0;
      mo_imm = '0; mo_pc = '0; mo_tag = '0;
    end
    if (issue_valid && fr >= 0) begin
      nx[fr].busy = 1'b1;
      nx[fr].op = issue_op;
      nx[fr].imm = issue_imm;
      nx[fr].pc = issue_pc;
      nx[fr].tag = issue_rob_tag;
      nx[fr].v1 = issue_V1; nx[fr].w1 = issue_Q1_busy; nx[fr].q1 = issue_Q1;
      nx[fr].v2 = issue_V2; nx[fr].w2 = issue_Q2_busy; nx[fr].q2 = issue_Q2;
      if (nx[fr].w1 && bus_hit(issue_Q1, val)) begin
        nx[fr].v1 = val; nx[fr].w1 = 1'b0;
      end
      if (nx[fr].w2 && bus_hit(issue_Q2, val)) begin
        nx[fr].v2 = val; nx[fr].w2 = 1'b0;
      end
    end
    m = nx;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        iv;
    logic [5:0]  op;
    logic [31:0] v1, v2;
    logic        q1b;
    logic [3:0]  q1, tag;
    logic        av;
    logic [3:0]  at;
    logic [31:0] ad;
    logic        lv;
    logic [3:0]  lt;
    logic [31:0] ld;
    logic [5:0]  e_op;
    logic [31:0] e_v1, e_v2;
    logic [3:0]  e_tag;
  } vec_t;

  localparam int NV = 18;
  vec_t tv [NV];

  task automatic setv(input int i, input int iv, input int op,
                      input int v1, input int v2, input int q1b,
                      input int q1, input int rt,
                      input int av, input int at, input int ad,
                      input int lv, input int lt, input int ld,
                      input int eop, input int ev1, input int ev2,
                      input int etag);
    tv[i].iv = iv[0]; tv[i].op = 6'(op);
    tv[i].v1 = v1; tv[i].v2 = v2;
    tv[i].q1b = q1b[0]; tv[i].q1 = 4'(q1); tv[i].tag = 4'(rt);
    tv[i].av = av[0]; tv[i].at = 4'(at); tv[i].ad = ad;
    tv[i].lv = lv[0]; tv[i].lt = 4'(lt); tv[i].ld = ld;
    tv[i].e_op = 6'(eop); tv[i].e_v1 = ev1; tv[i].e_v2 = ev2;
    tv[i].e_tag = 4'(etag);
  endtask

  int pri_op [6] = '{20, 21, 9, 22, 23, 10};
  int pri_q  [6] = '{11, 12, 6, 13, 14, 6};

  initial begin
    logic [31:0] r;
    rst = 1'b1;
    idle();
    model_reset();

    //    i iv op v1     v2 q1b q1 tg av at ad   lv lt ld     eop ev1    ev2 etg
    setv( 0, 1, 1, 5,     7, 0, 0, 3, 0, 0, 0,   0, 0, 0,     0, 0,     0, 0);
    setv( 1, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     1, 5,     7, 3);
    setv( 2, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     0, 0,     0, 0);
    setv( 3, 1, 2, 0,     0, 1, 9, 1, 0, 0, 0,   0, 0, 0,     0, 0,     0, 0);
    setv( 4, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     0, 0,     0, 0);
    setv( 5, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,   1, 9, 'h100, 0, 0,     0, 0);
    setv( 6, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     2, 'h100, 0, 1);
    setv( 7, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     0, 0,     0, 0);
    setv( 8, 1, 3, 0,     3, 1, 9, 2, 0, 0, 0,   1, 9, 'h55,  0, 0,     0, 0);
    setv( 9, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     3, 'h55,  3, 2);
    setv(10, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     0, 0,     0, 0);
    setv(11, 1, 4, 0,     0, 1, 6, 5, 1, 7, 9,   0, 0, 0,     0, 0,     0, 0);
    setv(12, 0, 0, 0,     0, 0, 0, 0, 1, 6, 1,   1, 6, 2,     0, 0,     0, 0);
    setv(13, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     4, 1,     0, 5);
    setv(14, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     0, 0,     0, 0);
    setv(15, 1, 5, 0,     2, 1, 8, 6, 1, 8, 'h33, 1, 8, 'h44, 0, 0,     0, 0);
    setv(16, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     5, 'h33,  2, 6);
    setv(17, 0, 0, 0,     0, 0, 0, 0, 0, 0, 0,   0, 0, 0,     0, 0,     0, 0);

    // reset state
    tick();
    chk("rst.full", 32'(full), 0);
    expect_out("rst", 0, 0, 0, 0);
    chk("rst.imm", alu_imm, 0);
    chk("rst.pc", alu_inst_pos, 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      idle();
      issue_valid = tv[i].iv; issue_op = tv[i].op;
      issue_V1 = tv[i].v1; issue_V2 = tv[i].v2;
      issue_Q1_busy = tv[i].q1b; issue_Q1 = tv[i].q1;
      issue_rob_tag = tv[i].tag;
      issue_imm = 32'(i); issue_pc = 32'h1000 + 32'(i * 4);
      alu_cdb_valid = tv[i].av; alu_cdb_tag = tv[i].at;
      alu_cdb_value = tv[i].ad;
      lsb_cdb_valid = tv[i].lv; lsb_cdb_tag = tv[i].lt;
      lsb_cdb_value = tv[i].ld;
      tick();
      expect_out($sformatf("vec%0d", i), int'(tv[i].e_op),
                 int'(tv[i].e_v1), int'(tv[i].e_v2), int'(tv[i].e_tag));
    end

    // fill to capacity, reject extra, wake entry 10, refill its slot
    do_reset();
    for (int i = 0; i < 16; i++) begin
      idle();
      iss(5, 0, 1, i, 0, i);
      tick();
      chk($sformatf("fill%0d.op", i), 32'(alu_op_enum), 0);
      if (i == 14) chk("fill.notfull", 32'(full), 0);
    end
    chk("fill.full", 32'(full), 1);
    idle();
    iss(6, 'h66, 0, 0, 0, 0);
    tick();
    chk("over.full", 32'(full), 1);
    chk("over.op", 32'(alu_op_enum), 0);
    idle();
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd10; alu_cdb_value = 32'hAA;
    tick();
    chk("wake10.full", 32'(full), 1);
    chk("wake10.op", 32'(alu_op_enum), 0);
    idle();
    tick();
    expect_out("disp10", 5, 'hAA, 0, 10);
    chk("disp10.full", 32'(full), 0);
    iss(7, 'h77, 0, 0, 1, 12);
    tick();
    chk("refill.full", 32'(full), 1);
    chk("refill.op", 32'(alu_op_enum), 0);
    idle();
    tick();
    expect_out("refill.disp", 7, 'h77, 1, 12);

    // lowest index first; both buses on one tag, ALU value wins
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      iss(pri_op[i], 0, 1, pri_q[i], 0, i);
      tick();
      chk($sformatf("pri%0d.op", i), 32'(alu_op_enum), 0);
    end
    idle();
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd6; alu_cdb_value = 32'd1;
    lsb_cdb_valid = 1'b1; lsb_cdb_tag = 4'd6; lsb_cdb_value = 32'd2;
    tick();
    chk("pri.wake.op", 32'(alu_op_enum), 0);
    idle();
    tick();
    expect_out("pri.idx2", 9, 1, 0, 2);
    tick();
    expect_out("pri.idx5", 10, 1, 0, 5);

    // asynchronous reset between edges with entries still pending
    #3 rst = 1'b1;
    #1;
    chk("arst.full", 32'(full), 0);
    chk("arst.op", 32'(alu_op_enum), 0);
    #1 rst = 1'b0;
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd11;
    lsb_cdb_valid = 1'b1; lsb_cdb_tag = 4'd12;
    tick();
    alu_cdb_tag = 4'd13; lsb_cdb_tag = 4'd14;
    tick();
    chk("arst.idle1", 32'(alu_op_enum), 0);
    idle();
    tick();
    chk("arst.idle2", 32'(alu_op_enum), 0);
    iss(13, 'h13, 0, 0, 0, 7);
    tick();
    idle();
    tick();
    expect_out("arst.new", 13, 'h13, 0, 7);

    // clear beats concurrent issue and dispatch candidate
    idle();
    iss(14, 0, 1, 3, 0, 8);
    tick();
    idle();
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd3; alu_cdb_value = 32'h99;
    tick();
    idle();
    clear = 1'b1;
    iss(15, 'h15, 0, 0, 0, 9);
    tick();
    chk("clr.op", 32'(alu_op_enum), 0);
    chk("clr.full", 32'(full), 0);
    idle();
    tick();
    chk("clr.after1", 32'(alu_op_enum), 0);
    tick();
    chk("clr.after2", 32'(alu_op_enum), 0);

    // rdy low freezes everything, including a live dispatch
    iss(12, 'h12, 0, 0, 0, 4);
    tick();
    idle();
    tick();
    expect_out("frz.pre", 12, 'h12, 0, 4);
    for (int i = 0; i < 3; i++) begin
      iss(16, 'h16, 0, 0, 0, 11);
      rdy = 1'b0;
      alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd1;
      tick();
      expect_out($sformatf("frz%0d", i), 12, 'h12, 0, 4);
    end
    idle();
    tick();
    chk("frz.post1", 32'(alu_op_enum), 0);
    tick();
    chk("frz.post2", 32'(alu_op_enum), 0);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      r = $urandom;
      rdy = (r[2:0] != 3'd0);
      clear = ($urandom_range(0, 39) == 0);
      issue_valid = !m_full() && r[3];
      issue_op = 6'($urandom_range(1, 63));
      issue_V1 = $urandom; issue_V2 = $urandom;
      issue_imm = $urandom; issue_pc = $urandom;
      issue_Q1_busy = r[4]; issue_Q1 = r[11:8];
      issue_Q2_busy = r[5] & r[6]; issue_Q2 = r[15:12];
      issue_rob_tag = r[29:26];
      alu_cdb_valid = r[16]; alu_cdb_tag = r[20:17];
      lsb_cdb_valid = r[21]; lsb_cdb_tag = r[25:22];
      alu_cdb_value = $urandom; lsb_cdb_value = $urandom;
      model_edge();
      tick();
      chk("rnd.full", 32'(full), 32'(m_full()));
      chk("rnd.op", 32'(alu_op_enum), 32'(mo_op));
      chk("rnd.v1", alu_V1, mo_v1);
      chk("rnd.v2", alu_V2, mo_v2);
      chk("rnd.imm", alu_imm, mo_imm);
      chk("rnd.pc", alu_inst_pos, mo_pc);
      chk("rnd.tag", 32'(alu_rob_tag), 32'(mo_tag));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
